display_capture: RTL and testbench

Receiving end of the multiplexed 4-digit display stream produced by the cycle-computer mode controller (bcd_out / nDigit / DP). Demultiplexes the time-sliced digit strobes into four frame-coherent digit registers. Checks strobe ordering, decodes the mode letter shown on digit 0, and flags lamp-test and stale-display conditions. Sits between the mode controller and the display/monitor logic, on the same clock.

---
 rtl/display_capture.sv | 202 ++++++++++++++++++++
 tb/tb_display_capture.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_capture.sv
// display_capture: demultiplexes the time-sliced 4-digit display stream
// (bcd / nDigit / DP) into frame-coherent digit registers, checks strobe
// ordering, decodes the mode letter on digit 0, and reports lamp-test and
// stale-display conditions. All outputs are registered.
module display_capture #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             Rst,
  input  logic [3:0]       bcd_in,
  input  logic [3:0]       nDigit_in,
  input  logic             DP_in,
  output logic [3:0]       digit0,
  output logic [3:0]       digit1,
  output logic [3:0]       digit2,
  output logic [3:0]       digit3,
  output logic [3:0]       dp_out,
  output logic [2:0]       mode,
  output logic             mode_valid,
  output logic             frame_valid,
  output logic [CNT_W-1:0] frame_count,
  output logic             seq_err,
  output logic             lamp_test,
  output logic             stale
);

  localparam logic [1:0] WAIT0 = 2'd0;
  localparam logic [1:0] EXP1  = 2'd1;
  localparam logic [1:0] EXP2  = 2'd2;
  localparam logic [1:0] EXP3  = 2'd3;

  localparam int            TW    = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT - 1);

  // Mode letter decode: returns {valid, mode}; non-letter codes map to 7.
  function automatic logic [3:0] decode_mode(input logic [3:0] code);
    case (code)
      4'd10:   decode_mode = 4'b1_000;
      4'd11:   decode_mode = 4'b1_001;
      4'd12:   decode_mode = 4'b1_010;
      4'd13:   decode_mode = 4'b1_011;
      4'd14:   decode_mode = 4'b1_100;
      default: decode_mode = 4'b0_111;
    endcase
  endfunction

  logic [1:0]    state_r;
  logic [1:0]    state_nx_s;
  logic [3:0]    pos_s;
  logic          lamp_s;
  logic          illegal_s;
  logic          cap_en_s;
  logic [1:0]    cap_idx_s;
  logic          commit_s;
  logic          err_s;
  logic [3:0]    shad0_r;
  logic [3:0]    shad1_r;
  logic [3:0]    shad2_r;
  logic [2:0]    sdp_r;
  logic [TW-1:0] tcnt_r;
  logic [TW-1:0] tcnt_nx_s;
  logic          stale_nx_s;
  logic [3:0]    mode_dec_s;

  // Classify the strobe pattern: one-hot slot, lamp test, or illegal.
  always_comb begin
    pos_s     = 4'b0000;
    lamp_s    = 1'b0;
    illegal_s = 1'b0;
    case (nDigit_in)
      4'b0111: pos_s     = 4'b0001;
      4'b1011: pos_s     = 4'b0010;
      4'b1101: pos_s     = 4'b0100;
      4'b1110: pos_s     = 4'b1000;
      4'b1111: pos_s     = 4'b0000;
      4'b0000: lamp_s    = 1'b1;
      default: illegal_s = 1'b1;
    endcase
  end

  // Frame sequencing: decide capture, commit, error and next state.
  always_comb begin
    state_nx_s = state_r;
    cap_en_s   = 1'b0;
    cap_idx_s  = 2'd0;
    commit_s   = 1'b0;
    err_s      = 1'b0;
    if (illegal_s) begin
      err_s      = 1'b1;
      state_nx_s = WAIT0;
    end else if (pos_s[0]) begin
      // A new frame start always restarts; aborting a frame past slot 1 is an error.
      cap_en_s   = 1'b1;
      cap_idx_s  = 2'd0;
      state_nx_s = EXP1;
      err_s      = (state_r == EXP2) || (state_r == EXP3);
    end else if (pos_s[1]) begin
      case (state_r)
        WAIT0:   state_nx_s = WAIT0;
        EXP1:    begin cap_en_s = 1'b1; cap_idx_s = 2'd1; state_nx_s = EXP2; end
        EXP2:    begin cap_en_s = 1'b1; cap_idx_s = 2'd1; state_nx_s = EXP2; end
        default: begin err_s = 1'b1; state_nx_s = WAIT0; end
      endcase
    end else if (pos_s[2]) begin
      case (state_r)
        WAIT0:   state_nx_s = WAIT0;
        EXP2:    begin cap_en_s = 1'b1; cap_idx_s = 2'd2; state_nx_s = EXP3; end
        EXP3:    begin cap_en_s = 1'b1; cap_idx_s = 2'd2; state_nx_s = EXP3; end
        default: begin err_s = 1'b1; state_nx_s = WAIT0; end
      endcase
    end else if (pos_s[3]) begin
      case (state_r)
        WAIT0:   state_nx_s = WAIT0;
        EXP3:    begin commit_s = 1'b1; state_nx_s = WAIT0; end
        default: begin err_s = 1'b1; state_nx_s = WAIT0; end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Stale-display timer: cleared by a commit, otherwise saturating count.
  always_comb begin
    if (commit_s) begin
      tcnt_nx_s  = {TW{1'b0}};
      stale_nx_s = 1'b0;
    end else begin
      if (tcnt_r == T_MAX) begin
        tcnt_nx_s = T_MAX;
      end else begin
        tcnt_nx_s = tcnt_r + {{(TW-1){1'b0}}, 1'b1};
      end
      // Sticky so the display stays stale from reset until the first commit.
      stale_nx_s = stale | (tcnt_nx_s == T_MAX);
    end
  end

  assign mode_dec_s = decode_mode(shad0_r);

  // State register and shadow capture of the frame in progress.
  always_ff @(posedge clock) begin
    if (Rst) begin
      state_r <= WAIT0;
      shad0_r <= 4'd0;
      shad1_r <= 4'd0;
      shad2_r <= 4'd0;
      sdp_r   <= 3'b000;
    end else begin
      state_r <= state_nx_s;
      if (cap_en_s) begin
        case (cap_idx_s)
          2'd0:    begin shad0_r <= bcd_in; sdp_r[0] <= DP_in; end
          2'd1:    begin shad1_r <= bcd_in; sdp_r[1] <= DP_in; end
          2'd2:    begin shad2_r <= bcd_in; sdp_r[2] <= DP_in; end
          default: begin end
        endcase
      end
    end
  end

  // Committed frame: digits, decimal points, mode and frame counter.
  always_ff @(posedge clock) begin
    if (Rst) begin
      digit0      <= 4'd0;
      digit1      <= 4'd0;
      digit2      <= 4'd0;
      digit3      <= 4'd0;
      dp_out      <= 4'b0000;
      mode        <= 3'd7;
      mode_valid  <= 1'b0;
      frame_count <= {CNT_W{1'b0}};
    end else if (commit_s) begin
      digit0      <= shad0_r;
      digit1      <= shad1_r;
      digit2      <= shad2_r;
      digit3      <= bcd_in;
      dp_out      <= {sdp_r[0], sdp_r[1], sdp_r[2], DP_in};
      mode        <= mode_dec_s[2:0];
      mode_valid  <= mode_dec_s[3];
      frame_count <= frame_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Per-cycle status pulses and the stale timer registers.
  always_ff @(posedge clock) begin
    if (Rst) begin
      frame_valid <= 1'b0;
      seq_err     <= 1'b0;
      lamp_test   <= 1'b0;
      tcnt_r      <= {TW{1'b0}};
      stale       <= 1'b1;
    end else begin
      frame_valid <= commit_s;
      seq_err     <= err_s;
      lamp_test   <= lamp_s;
      tcnt_r      <= tcnt_nx_s;
      stale       <= stale_nx_s;
    end
  end

endmodule

// File: tb/tb_display_capture.sv
// Self-checking bench for display_capture: directed scenarios plus a
// randomized stream compared against a slot-progress reference model.
module tb_display_capture;

  localparam int TO    = 16;
  localparam int CNT_W = 8;

  logic             clock = 1'b0;
  logic             Rst;
  logic [3:0]       bcd_in;
  logic [3:0]       nDigit_in;
  logic             DP_in;
  logic [3:0]       digit0, digit1, digit2, digit3;
  logic [3:0]       dp_out;
  logic [2:0]       mode;
  logic             mode_valid;
  logic             frame_valid;
  logic [CNT_W-1:0] frame_count;
  logic             seq_err;
  logic             lamp_test;
  logic             stale;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [3:0] m_dig [4];
  logic [3:0] m_part [3];
  logic [2:0] m_pdp;
  logic [3:0] m_dp;
  logic [2:0] m_mode;
  logic       m_mv, m_fv, m_err, m_lamp, m_stale;
  logic [7:0] m_fc;
  int         m_p;      // number of leading slots of the current frame already held
  int         m_since;  // edges since the last commit

  display_capture #(.TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clock(clock), .Rst(Rst), .bcd_in(bcd_in), .nDigit_in(nDigit_in), .DP_in(DP_in),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .dp_out(dp_out), .mode(mode), .mode_valid(mode_valid), .frame_valid(frame_valid),
    .frame_count(frame_count), .seq_err(seq_err), .lamp_test(lamp_test), .stale(stale)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  task automatic model_step(input logic r, input logic [3:0] b, input logic [3:0] nd, input logic d);
    int  k;
    bit  commit;
    if (r) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 4'd0;
      for (int i = 0; i < 3; i++) m_part[i] = 4'd0;
      m_pdp = 3'b000; m_dp = 4'b0000; m_mode = 3'd7; m_mv = 1'b0; m_fv = 1'b0;
      m_err = 1'b0; m_lamp = 1'b0; m_fc = 8'd0; m_p = 0; m_since = TO; m_stale = 1'b1;
    end else begin
      commit = 1'b0;
      m_fv   = 1'b0;
      m_err  = 1'b0;
      m_lamp = (nd == 4'b0000);
      k = -1;
      for (int j = 0; j < 4; j++) if (nd == ~(4'b1000 >> j)) k = j;
      if (nd == 4'b1111 || nd == 4'b0000) begin
      end else if (k < 0) begin
        m_err = 1'b1; m_p = 0;
      end else if (k == 0) begin
        if (m_p >= 2) m_err = 1'b1;
        m_part[0] = b; m_pdp[0] = d; m_p = 1;
      end else if (m_p == 0) begin
      end else if (m_p == k) begin
        if (k == 3) commit = 1'b1;
        else begin m_part[k] = b; m_pdp[k] = d; m_p = k + 1; end
      end else if (m_p == k + 1) begin
        m_part[k] = b; m_pdp[k] = d;
      end else begin
        m_err = 1'b1; m_p = 0;
      end
      if (commit) begin
        m_dig[0] = m_part[0]; m_dig[1] = m_part[1]; m_dig[2] = m_part[2]; m_dig[3] = b;
        m_dp = {m_pdp[0], m_pdp[1], m_pdp[2], d};
        if (m_dig[0] >= 4'd10 && m_dig[0] <= 4'd14) begin
          m_mode = 3'(m_dig[0] - 4'd10); m_mv = 1'b1;
        end else begin
          m_mode = 3'd7; m_mv = 1'b0;
        end
        m_fc = m_fc + 8'd1; m_fv = 1'b1; m_p = 0; m_since = 0;
      end else if (m_since < TO) begin
        m_since++;
      end
      m_stale = (m_since >= TO - 1);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] b, input logic [3:0] nd, input logic d);
    Rst = r; bcd_in = b; nDigit_in = nd; DP_in = d;
    model_step(r, b, nd, d);
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] e);
    drive(1'b0, a, 4'b0111, 1'b0);
    drive(1'b0, b, 4'b1011, 1'b0);
    drive(1'b0, c, 4'b1101, 1'b0);
    drive(1'b0, e, 4'b1110, 1'b0);
  endtask

  task automatic test_reset;
    drive(1'b1, 4'd0, 4'b1111, 1'b0);
    drive(1'b1, 4'd0, 4'b1111, 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 4'($urandom_range(0, 15)), 4'b1111, 1'($urandom_range(0, 1)));
      n_checks++;
      if ({digit0, digit1, digit2, digit3, dp_out} !== 20'd0 || mode !== 3'd7 || mode_valid !== 1'b0 ||
          stale !== 1'b1 || frame_count !== 8'd0 || frame_valid !== 1'b0 || seq_err !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got dig=%h dp=%b mode=%0d mv=%b stale=%b fc=%0d fv=%b err=%b, expected zeros mode 7 stale 1",
                 i, {digit0, digit1, digit2, digit3}, dp_out, mode, mode_valid, stale, frame_count, frame_valid, seq_err);
      end
    end
  endtask

  task automatic test_frame;
    drive(1'b0, 4'd10, 4'b0111, 1'b0);
    drive(1'b0, 4'd1,  4'b1011, 1'b0);
    drive(1'b0, 4'd2,  4'b1101, 1'b1);
    drive(1'b0, 4'd5,  4'b1110, 1'b0);
    n_checks++;
    if ({digit0, digit1, digit2, digit3} !== 16'hA125 || dp_out !== 4'b0010) begin
      n_fail++;
      $display("FAIL frame_digits: got dig=%h dp=%b, expected a125 dp=0010", {digit0, digit1, digit2, digit3}, dp_out);
    end
    n_checks++;
    if (mode !== 3'd0 || mode_valid !== 1'b1 || frame_valid !== 1'b1 || frame_count !== 8'd1 || stale !== 1'b0) begin
      n_fail++;
      $display("FAIL frame_status: got mode=%0d mv=%b fv=%b fc=%0d stale=%b, expected 0 1 1 1 0",
               mode, mode_valid, frame_valid, frame_count, stale);
    end
    drive(1'b0, 4'd0, 4'b1111, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b0 || digit0 !== 4'd10) begin
      n_fail++;
      $display("FAIL frame_pulse: got fv=%b digit0=%0d, expected fv=0 digit0=10", frame_valid, digit0);
    end
  endtask

  task automatic test_abort;
    drive(1'b0, 4'd13, 4'b0111, 1'b0);
    drive(1'b0, 4'd0,  4'b1011, 1'b0);
    drive(1'b0, 4'd7,  4'b1110, 1'b1);
    n_checks++;
    if (seq_err !== 1'b1 || frame_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_err: got err=%b fv=%b, expected 1 0", seq_err, frame_valid);
    end
    n_checks++;
    if ({digit0, digit1, digit2, digit3} !== 16'hA125 || frame_count !== 8'd1 || mode !== 3'd0) begin
      n_fail++;
      $display("FAIL abort_hold: got dig=%h fc=%0d mode=%0d, expected a125 1 0",
               {digit0, digit1, digit2, digit3}, frame_count, mode);
    end
    // Back in WAIT0: later slots are ignored silently
    drive(1'b0, 4'd3, 4'b1101, 1'b0);
    drive(1'b0, 4'd3, 4'b1110, 1'b0);
    n_checks++;
    if (seq_err !== 1'b0 || frame_valid !== 1'b0 || frame_count !== 8'd1) begin
      n_fail++;
      $display("FAIL wait0_ignore: got err=%b fv=%b fc=%0d, expected 0 0 1", seq_err, frame_valid, frame_count);
    end
  endtask

  task automatic test_lamp;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 4'd8, 4'b0000, 1'b1);
      n_checks++;
      if (lamp_test !== 1'b1 || seq_err !== 1'b0) begin
        n_fail++;
        $display("FAIL lamp_on %0d: got lamp=%b err=%b, expected 1 0", i, lamp_test, seq_err);
      end
    end
    drive(1'b0, 4'd0, 4'b1111, 1'b0);
    n_checks++;
    if (lamp_test !== 1'b0) begin
      n_fail++;
      $display("FAIL lamp_off: got %b, expected 0", lamp_test);
    end
    drive(1'b0, 4'd0, 4'b0101, 1'b0);
    n_checks++;
    if (seq_err !== 1'b1 || lamp_test !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_err: got err=%b lamp=%b, expected 1 0", seq_err, lamp_test);
    end
    drive(1'b0, 4'd0, 4'b1111, 1'b0);
    n_checks++;
    if (seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse: got err=%b, expected 0", seq_err);
    end
  endtask

  task automatic test_stale;
    send_frame(4'd11, 4'd3, 4'd4, 4'd5);
    n_checks++;
    if (stale !== 1'b0 || mode !== 3'd1 || mode_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL stale_commit: got stale=%b mode=%0d mv=%b, expected 0 1 1", stale, mode, mode_valid);
    end
    for (int i = 1; i <= 20; i++) begin
      drive(1'b0, 4'd0, 4'b1111, 1'b0);
      n_checks++;
      if (stale !== (i >= TO - 1)) begin
        n_fail++;
        $display("FAIL stale_rise %0d: got %b, expected %b", i, stale, (i >= TO - 1));
      end
    end
    drive(1'b0, 4'd12, 4'b0111, 1'b0);
    drive(1'b0, 4'd9,  4'b1011, 1'b0);
    drive(1'b0, 4'd9,  4'b1101, 1'b0);
    n_checks++;
    if (stale !== 1'b1) begin
      n_fail++;
      $display("FAIL stale_partial: got %b, expected 1", stale);
    end
    drive(1'b0, 4'd9, 4'b1110, 1'b0);
    n_checks++;
    if (stale !== 1'b0 || frame_valid !== 1'b1 || mode !== 3'd2) begin
      n_fail++;
      $display("FAIL stale_clear: got stale=%b fv=%b mode=%0d, expected 0 1 2", stale, frame_valid, mode);
    end
  endtask

  task automatic test_random;
    int          cursor;
    int          r;
    logic [3:0]  nd;
    logic [35:0] got, exp;
    cursor = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) begin
        nd = ~(4'b1000 >> cursor);
        cursor = (cursor + 1) % 4;
      end else if (r < 80) begin
        nd = ~(4'b1000 >> $urandom_range(0, 3));
      end else if (r < 86) begin
        nd = 4'b1111;
      end else if (r < 90) begin
        nd = 4'b0000;
      end else begin
        nd = 4'($urandom_range(0, 15));
        if (nd == 4'b0111 || nd == 4'b1011 || nd == 4'b1101 || nd == 4'b1110 ||
            nd == 4'b1111 || nd == 4'b0000) nd = 4'b1001;
      end
      drive(1'b0, 4'($urandom_range(0, 15)), nd, 1'($urandom_range(0, 1)));
      got = {digit0, digit1, digit2, digit3, dp_out, mode, mode_valid, frame_valid,
             frame_count, seq_err, lamp_test, stale};
      exp = {m_dig[0], m_dig[1], m_dig[2], m_dig[3], m_dp, m_mode, m_mv, m_fv,
             m_fc, m_err, m_lamp, m_stale};
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random cyc %0d nd=%b: got %h, expected %h", i, nd, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_fc;
    drive(1'b1, 4'd0, 4'b1111, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send_frame(4'($urandom_range(10, 14)), 4'($urandom_range(0, 9)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)));
      exp_fc = 8'(i + 1);
      n_checks++;
      if (frame_valid !== 1'b1 || frame_count !== exp_fc || {digit0, digit1, digit2, digit3} !== {m_dig[0], m_dig[1], m_dig[2], m_dig[3]}) begin
        n_fail++;
        $display("FAIL b2b frame %0d: got fv=%b fc=%0d dig=%h, expected 1 %0d %h", i, frame_valid, frame_count,
                 {digit0, digit1, digit2, digit3}, exp_fc, {m_dig[0], m_dig[1], m_dig[2], m_dig[3]});
      end
    end
    n_checks++;
    if (frame_count !== 8'd0) begin
      n_fail++;
      $display("FAIL b2b_wrap: got %0d, expected 0", frame_count);
    end
    drive(1'b0, 4'd10, 4'b0111, 1'b1);
    drive(1'b0, 4'd4,  4'b1011, 1'b1);
    drive(1'b1, 4'd4,  4'b1101, 1'b1);
    n_checks++;
    if ({digit0, digit1, digit2, digit3, dp_out} !== 20'd0 || mode !== 3'd7 || mode_valid !== 1'b0 ||
        frame_valid !== 1'b0 || frame_count !== 8'd0 || seq_err !== 1'b0 || lamp_test !== 1'b0 || stale !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_reset: got dig=%h dp=%b mode=%0d mv=%b fv=%b fc=%0d err=%b lamp=%b stale=%b, expected reset values",
               {digit0, digit1, digit2, digit3}, dp_out, mode, mode_valid, frame_valid, frame_count, seq_err, lamp_test, stale);
    end
    drive(1'b0, 4'd6, 4'b1110, 1'b0);
    n_checks++;
    if (frame_valid !== 1'b0 || frame_count !== 8'd0 || digit3 !== 4'd0 || seq_err !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_pos3: got fv=%b fc=%0d d3=%0d err=%b, expected 0 0 0 0",
               frame_valid, frame_count, digit3, seq_err);
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_abort();
    test_lamp();
    test_stale();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
